// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush handling and
// a saturating load-use bubble counter.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [9:0]        id_ctrl,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              flush,
  output logic              ex_valid,
  output logic [9:0]        ex_ctrl,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              r_valid;
  logic [9:0]        r_ctrl;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [2:0]        r_funct3;
  logic [6:0]        r_funct7;
  logic [CNT_W-1:0]  r_bubble_count;

  logic w_uses_rs1;
  logic w_uses_rs2;
  logic w_ex_is_load;
  logic w_load_use;

  // Operand usage of the ID instruction and load-use detection against EX.
  always_comb begin
    // JAL reads no register; R-type, store and branch also read rs2.
    w_uses_rs1   = ~id_ctrl[0];
    w_uses_rs2   = ~id_ctrl[9] | id_ctrl[5] | id_ctrl[2];
    w_ex_is_load = r_valid & r_ctrl[6] & (r_rd != 5'd0);
    w_load_use   = w_ex_is_load & id_valid &
                   ((w_uses_rs1 & (id_rs1 == r_rd)) | (w_uses_rs2 & (id_rs2 == r_rd)));
    // A flush kills the ID instruction anyway, so upstream need not hold.
    hazard_stall = w_load_use & ~flush;
  end

  // Pipeline register: flush and load-use both insert an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid        <= 1'b0;
      r_ctrl         <= '0;
      r_pc           <= '0;
      r_rd1          <= '0;
      r_rd2          <= '0;
      r_imm          <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_funct3       <= '0;
      r_funct7       <= '0;
      r_bubble_count <= '0;
    end else if (flush || w_load_use) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_pc     <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_funct3 <= '0;
      r_funct7 <= '0;
      // Only load-use bubbles are counted; the counter saturates.
      if (!flush && (r_bubble_count != {CNT_W{1'b1}})) begin
        r_bubble_count <= r_bubble_count + 1'b1;
      end
    end else begin
      r_valid  <= id_valid;
      r_ctrl   <= id_valid ? id_ctrl : 10'd0;
      r_pc     <= id_pc;
      r_rd1    <= id_rd1;
      r_rd2    <= id_rd2;
      r_imm    <= id_imm;
      r_rs1    <= id_rs1;
      r_rs2    <= id_rs2;
      r_rd     <= id_rd;
      r_funct3 <= id_funct3;
      r_funct7 <= id_funct7;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_ctrl      = r_ctrl;
  assign ex_pc        = r_pc;
  assign ex_rd1       = r_rd1;
  assign ex_rd2       = r_rd2;
  assign ex_imm       = r_imm;
  assign ex_rs1       = r_rs1;
  assign ex_rs2       = r_rs2;
  assign ex_rd        = r_rd;
  assign ex_funct3    = r_funct3;
  assign ex_funct7    = r_funct7;
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed table, reset, random and
// counter-saturation sequences against a behavioural model.
module tb_id_ex_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 32;
  // Narrow counter so saturation is reachable in a short run.
  localparam int unsigned CW = 8;
  localparam int          CNT_MAX = (1 << CW) - 1;

  localparam logic [9:0] C_RTYPE = 10'b0010010000;
  localparam logic [9:0] C_LW    = 10'b1111000000;
  localparam logic [9:0] C_ADDI  = 10'b1010000000;
  localparam logic [9:0] C_JAL   = 10'b1010000001;
  localparam logic [9:0] C_JALR  = 10'b1010000010;
  localparam logic [9:0] C_PASS  = 10'b0010000100;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [9:0]    id_ctrl;
  logic [PW-1:0] id_pc;
  logic [DW-1:0] id_rd1, id_rd2, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [2:0]    id_funct3;
  logic [6:0]    id_funct7;
  logic          flush;
  logic          ex_valid;
  logic [9:0]    ex_ctrl;
  logic [PW-1:0] ex_pc;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [2:0]    ex_funct3;
  logic [6:0]    ex_funct7;
  logic          hazard_stall;
  logic [CW-1:0] bubble_count;

  id_ex_stage_reg #(.DATA_W(DW), .PC_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7), .flush(flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .hazard_stall(hazard_stall),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [9:0]    ctrl;
    logic [PW-1:0] pc;
    logic [DW-1:0] rd1, rd2, imm;
    logic [4:0]    rs1, rs2, rd;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic          flush;
    logic          exp_stall;
    logic          exp_valid;
    int            exp_cnt;
  } vec_t;

  // Behavioural model of what EX should hold: one record per instruction.
  vec_t m_ex;
  int   m_cnt;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [9:0] c, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic fl,
                              input logic es, input logic ev, input int ec);
    vec_t t;
    t.valid = v; t.ctrl = c; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.flush = fl;
    t.pc = 32'h100 + {27'd0, rd, 2'b00}; t.rd1 = 32'h1000 + rs1; t.rd2 = 32'h2000 + rs2;
    t.imm = 32'hFFFF_FF00 | rd; t.f3 = rd[2:0]; t.f7 = {2'b0, rs1};
    t.exp_stall = es; t.exp_valid = ev; t.exp_cnt = ec;
    return t;
  endfunction

  function automatic vec_t empty_ex();
    vec_t t;
    t = mk(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 0);
    t.pc = '0; t.rd1 = '0; t.rd2 = '0; t.imm = '0; t.f3 = '0; t.f7 = '0;
    return t;
  endfunction

  // Load-use as stated in terms of instruction semantics.
  function automatic bit model_load_use(input vec_t id);
    bit reads_rs1, reads_rs2;
    reads_rs1 = !id.ctrl[0];
    reads_rs2 = !id.ctrl[9] || id.ctrl[5] || id.ctrl[2];
    if (!(m_ex.valid && m_ex.ctrl[6] && m_ex.rd != 0 && id.valid)) return 0;
    return (reads_rs1 && id.rs1 == m_ex.rd) || (reads_rs2 && id.rs2 == m_ex.rd);
  endfunction

  task automatic check_ex(input string tag);
    chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(m_ex.valid));
    chk({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(m_ex.ctrl));
    chk({tag, ".ex_pc"}, 64'(ex_pc), 64'(m_ex.pc));
    chk({tag, ".ex_data"}, {ex_rd1, ex_rd2}, {m_ex.rd1, m_ex.rd2});
    chk({tag, ".ex_imm"}, 64'(ex_imm), 64'(m_ex.imm));
    chk({tag, ".ex_regs"}, 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m_ex.rs1, m_ex.rs2, m_ex.rd}));
    chk({tag, ".ex_funct"}, 64'({ex_funct3, ex_funct7}), 64'({m_ex.f3, m_ex.f7}));
    chk({tag, ".bubble_count"}, 64'(bubble_count), 64'(m_cnt));
  endtask

  // Present one ID instruction for one cycle and check against the model.
  task automatic apply(input vec_t v, input string tag, output logic stall_seen);
    bit lu;
    @(negedge clk);
    id_valid = v.valid; id_ctrl = v.ctrl; id_pc = v.pc; id_rd1 = v.rd1; id_rd2 = v.rd2;
    id_imm = v.imm; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_funct3 = v.f3;
    id_funct7 = v.f7; flush = v.flush;
    #1;
    lu = model_load_use(v);
    stall_seen = hazard_stall;
    chk({tag, ".hazard_stall"}, 64'(hazard_stall), 64'(lu && !v.flush));
    @(posedge clk);
    if (v.flush || lu) begin
      m_ex = empty_ex();
      if (!v.flush && m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_ex = v;
      if (!v.valid) m_ex.ctrl = '0;
    end
    #1;
    check_ex(tag);
  endtask

  function automatic vec_t rand_vec();
    vec_t t;
    t = mk(($urandom_range(0, 99) < 85), 10'($urandom), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 10), 1'b0, 1'b0, 0);
    if ($urandom_range(0, 99) < 40) t.ctrl[6] = 1'b1;
    t.pc = $urandom; t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom;
    t.f3 = 3'($urandom); t.f7 = 7'($urandom);
    return t;
  endfunction

  vec_t tbl[16];
  logic st;
  vec_t v;

  initial begin
    reset = 1'b0; flush = 1'b0; id_valid = 1'b0; id_ctrl = '0; id_pc = '0; id_rd1 = '0;
    id_rd2 = '0; id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct3 = '0;
    id_funct7 = '0;
    m_ex = empty_ex(); m_cnt = 0;

    // Directed table: {inputs, expected stall, expected ex_valid, expected count}.
    tbl[0]  = mk(1, C_PASS,  5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    tbl[0].pc = 32'h40; tbl[0].rd1 = 32'd5; tbl[0].rd2 = 32'd7;
    tbl[1]  = mk(1, C_LW,    5'd1, 5'd0, 5'd5, 0, 0, 1, 0);
    tbl[2]  = mk(1, C_RTYPE, 5'd5, 5'd6, 5'd7, 0, 1, 0, 1);  // load-use
    tbl[3]  = mk(1, C_RTYPE, 5'd5, 5'd6, 5'd7, 0, 0, 1, 1);  // advances after bubble
    tbl[4]  = mk(1, C_LW,    5'd2, 5'd0, 5'd0, 0, 0, 1, 1);
    tbl[5]  = mk(1, C_RTYPE, 5'd0, 5'd0, 5'd8, 0, 0, 1, 1);  // load to x0
    tbl[6]  = mk(1, C_LW,    5'd2, 5'd0, 5'd5, 0, 0, 1, 1);
    tbl[7]  = mk(1, C_ADDI,  5'd1, 5'd5, 5'd9, 0, 0, 1, 1);  // rs2 unused
    tbl[8]  = mk(1, C_LW,    5'd2, 5'd0, 5'd5, 0, 0, 1, 1);
    tbl[9]  = mk(1, C_JAL,   5'd5, 5'd5, 5'd1, 0, 0, 1, 1);  // jal never stalls
    tbl[10] = mk(1, C_LW,    5'd3, 5'd0, 5'd5, 0, 0, 1, 1);
    tbl[11] = mk(1, C_RTYPE, 5'd5, 5'd0, 5'd4, 1, 0, 0, 1);  // flush beats load-use
    tbl[12] = mk(1, C_LW,    5'd3, 5'd0, 5'd6, 0, 0, 1, 1);
    tbl[13] = mk(1, C_JALR,  5'd6, 5'd0, 5'd1, 0, 1, 0, 2);  // jalr checks rs1
    tbl[14] = mk(1, C_JALR,  5'd6, 5'd0, 5'd1, 0, 0, 1, 2);
    tbl[15] = mk(0, C_LW,    5'd6, 5'd6, 5'd2, 0, 0, 0, 2);  // invalid: ctrl forced 0

    #2;
    chk("reset.ex_valid", 64'(ex_valid), 64'd0);
    chk("reset.bubble_count", 64'(bubble_count), 64'd0);
    chk("reset.hazard_stall", 64'(hazard_stall), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("tbl%0d", i), st);
      chk($sformatf("tbl%0d.stall_exp", i), 64'(st), 64'(tbl[i].exp_stall));
      chk($sformatf("tbl%0d.valid_exp", i), 64'(ex_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d.cnt_exp", i), 64'(bubble_count), 64'(tbl[i].exp_cnt));
    end

    // Asynchronous reset between edges, with a pending load-use in ID.
    apply(mk(1, C_LW, 5'd1, 5'd0, 5'd9, 0, 0, 0, 0), "pre_rst", st);
    @(negedge clk);
    id_valid = 1'b1; id_ctrl = C_RTYPE; id_rs1 = 5'd9; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    m_ex = empty_ex(); m_cnt = 0;
    check_ex("async_rst");
    chk("async_rst.hazard_stall", 64'(hazard_stall), 64'd0);
    @(posedge clk); #1;
    check_ex("rst_held");
    @(negedge clk); reset = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      v = rand_vec();
      apply(v, "rand", st);
    end

    // Drive load-use pairs until the counter saturates, then one more.
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      apply(mk(1, C_LW, 5'd1, 5'd0, 5'd5, 0, 0, 0, 0), "sat_lw", st);
      apply(mk(1, C_RTYPE, 5'd5, 5'd5, 5'd7, 0, 0, 0, 0), "sat_use", st);
      apply(mk(1, C_RTYPE, 5'd5, 5'd5, 5'd7, 0, 0, 0, 0), "sat_adv", st);
    end
    apply(mk(1, C_LW, 5'd1, 5'd0, 5'd5, 0, 0, 0, 0), "sat_last_lw", st);
    apply(mk(1, C_RTYPE, 5'd1, 5'd5, 5'd7, 0, 0, 0, 0), "sat_last_use", st);
    chk("sat.stall", 64'(st), 64'd1);
    chk("sat.bubble", 64'(ex_valid), 64'd0);
    chk("sat.count", 64'(bubble_count), 64'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the five-stage RISC-V core, placed directly downstream of the decode-stage control decoder. It captures the decoded control bundle and the operand/data fields of the instruction in ID and presents them to EX one cycle later. It contains the load-use hazard detector, which inserts exactly one bubble when the instruction in ID reads the destination of a load in EX. It also honours a flush request from branch/jump resolution and counts inserted load-use bubbles for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of register operands and immediate
- PC_W, 32, width of PC field
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  10  packed {ALUSrc[9], MemtoReg[8], RegWrite[7], MemRead[6], MemWrite[5], ALUOp[4:3], Branch[2], JalrSel[1], Jump[0]}
- id_pc  in  PC_W  PC of ID instruction
- id_rd1, id_rd2  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register addresses
- id_funct3  in  3;  id_funct7  in  7  ALU controller fields
- flush  in  1  EX-stage redirect (taken branch, JAL, JALR); kill ID instruction
- ex_valid  out  1  registered valid
- ex_ctrl  out  10  registered control bundle, same bit order
- ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7  out  registered copies of the id_* fields
- hazard_stall  out  1  combinational; PC and IF/ID must hold this cycle
- bubble_count  out  CNT_W  saturating count of load-use bubbles

## Operation
- Operand use, derived from id_ctrl: uses_rs1 = !Jump; uses_rs2 = !ALUSrc | MemWrite | Branch (R-type, store, branch).
- load_use = ex_valid & ex_ctrl[6] & (ex_rd != 0) & id_valid & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)).
- hazard_stall = load_use & !flush.
- Per rising edge, priority order:
  1. flush=1: load bubble; bubble_count unchanged.
  2. load_use=1: load bubble; bubble_count += 1, saturating at 2^CNT_W-1.
  3. Otherwise: load all id_* into ex_*, ex_valid <= id_valid. If id_valid=0, ex_ctrl is forced to 0.
- Bubble: ex_valid=0 and every ex_* output 0, including data fields, so the output is deterministic.
- The stage has no internal hold. On a stall, upstream keeps presenting the same ID instruction. The bubble in EX clears load_use, so the instruction advances on the next edge.
- reset low: all ex_* = 0, ex_valid = 0, bubble_count = 0, asynchronously, regardless of clk. hazard_stall then evaluates to 0. Release is sampled at the next rising edge.

## Timing
- Latency: ID to EX, one cycle.
- hazard_stall is valid in the same cycle as the offending ID inputs. Path: ex_* flops → comparators → output, with no flop on it.
- A load-use stall lasts exactly one cycle. Two loads in a row to the same rd with a dependent third instruction also cost one bubble only.
- A flush in the same cycle as a load_use produces one bubble. hazard_stall=0 and the counter does not increment.
- A load with rd=x0 never stalls.
- JAL (Jump=1) after a load never stalls. For JALR, only rs1 is checked.
- Counter at saturation holds its value; it never wraps.

## Test plan
- Reset: drive a valid R-type through, then pull reset low between edges → all ex_* and bubble_count read 0 before the next clk edge. hazard_stall=0.
- Pass-through: id_valid=1, id_ctrl=10'b0010000100, id_pc=0x40, id_rd1=5, id_rd2=7, id_rd=3 → after one edge ex_* match exactly and ex_valid=1.
- Load-use: lw with ex_rd=5 in EX; ID holds add rs1=5 → hazard_stall=1 that cycle. Next edge: ex_valid=0, ex_ctrl=0, bubble_count=1. Following edge: add in EX and hazard_stall=0.
- No-false-stall cases, each → hazard_stall=0 and no bubble:
  - load rd=0 followed by use of x0;
  - load rd=5 followed by addi with rs2 field=5 (rs2 unused);
  - load rd=5 followed by jal.
- Flush priority: load_use and flush=1 in the same cycle → hazard_stall=0, bubble inserted, bubble_count unchanged.
- Saturation: preload with 65535 load-use events, add one more → bubble_count stays 0xFFFF and the bubble is still inserted.
